alu_result_stage: RTL and testbench
===================================

// Module: alu_result_stage
// PURPOSE
//  Pipeline stage directly downstream of the ALU. Registers RZ, opcode and flags per accepted op,
//  owns the architectural Condition Control Register (CCR), resolves BEQ/BNE/BLT taken, and
//  hands results to writeback through a 2-entry skid buffer (valid/ready both sides).
//  ccr_carry feeds back to the ALU carry input for ROR/ROL.
// PARAMETERS
//  DATA_W   32  RZ / opcode width
//  OP_NOP   0   opcode: no CCR update, no branch
//  OP_BEQ   39  branch if Z
//  OP_BNE   40  branch if !Z
//  OP_BLT   41  branch if N^V
// PORTS
//  Clock            in   1       rising-edge clock; sole clock
//  Reset            in   1       synchronous, active-high
//  in_valid         in   1       ALU result valid this cycle
//  in_ready         out  1       stage can accept (registered)
//  in_op            in   DATA_W  ALU_Op of this result
//  in_rz            in   DATA_W  ALU RZ
//  in_c/in_v/in_z/in_n/in_inr  in 1 each  ALU flags
//  in_ccr_en        in   1       ALU CCR_Enable
//  out_valid        out  1       head entry valid
//  out_ready        in   1       writeback accepts head
//  out_op           out  DATA_W  head opcode
//  out_rz           out  DATA_W  head RZ
//  out_br_taken     out  1       head is BEQ/BNE/BLT and condition true
//  ccr_q            out  32      CCR: [0]C [1]N [2]V [3]Z [4]INR [5]NOP [31:6]=0
//  ccr_carry        out  1       ccr_q[0], to ALU
// BEHAVIOUR
//  Reset: in_ready=0 for the reset cycle, then 1; out_valid=0; out_op/out_rz=0; out_br_taken=0;
//   ccr_q=0. Reset wins over any simultaneous handshake; in-flight entries discarded.
//  Accept = in_valid & in_ready; drain = out_valid & out_ready.
//  FSM: EMPTY(0 entries) / ONE / TWO. in_ready = (state!=TWO), registered from next state.
//   EMPTY: accept -> ONE.  ONE: accept&!drain -> TWO; drain&!accept -> EMPTY; both -> ONE.
//   TWO: drain -> ONE (skid entry becomes head next cycle); no accept possible.
//  Latency: accepted in cycle N -> out_valid in N+1 if buffer was empty. Order strictly FIFO.
//  Head held stable (op/rz/br_taken) while out_valid & !out_ready.
//  CCR updates at accept time (not drain), in program order, independent of output stall:
//   if accept & in_ccr_en & in_op!=OP_NOP: ccr_q <= {26'b0, 1'b0, in_inr, in_z, in_v, in_n, in_c}.
//   if accept & in_op==OP_NOP: ccr_q[5] <= 1, other bits hold. Otherwise ccr_q holds.
//  Branch resolution uses the branch op's own incoming flags (the ALU subtraction), captured
//   with the entry: BEQ: z; BNE: !z; BLT: n^v; any other op: 0.
//  Opcode compare is full-width equality on in_op.
//  No combinational path from in_* to out_*; in_ready not combinational on out_ready.
// STRUCTURE
//  Shared package: opcode constants (OP_NOP, OP_BEQ, OP_BNE, OP_BLT), CCR bit indices,
//   FSM state encoding.
//  One sub-module natural: skid_buffer_2 (width = DATA_W*2+1, holds op/rz/br_taken + FSM).
//  CCR register and branch compare live in the top level.
// TESTING
//  1 Reset then ADD(op 1) rz=5,c=0,z=0,ccr_en=1, out_ready=1 -> out_valid N+1, out_rz=5, ccr_q=0.
//  2 SUB op 2 rz=0,z=1 then BEQ(39) z=1, then BNE(40) z=1 -> br_taken 1 then 0; BLT(41) n=1,v=0 -> 1.
//  3 out_ready=0, 3 back-to-back valids -> in_ready drops after 2nd; 3rd held by source;
//    release out_ready -> outputs in order 1,2,3, no loss/duplication.
//  4 ASR(9) c=1 accepted while output stalled -> ccr_q[0]=1 and ccr_carry=1 next cycle.
//  5 NOP(0) with flags z=1 -> ccr_q[3:0] unchanged, ccr_q[5]=1; out_br_taken=0.
//  6 Reset asserted in state TWO -> next cycle out_valid=0, ccr_q=0, then in_ready=1.

Source files
------------

// File: rtl/alu_result_stage_pkg.sv
// Shared definitions for the ALU result stage: opcodes, CCR bit layout,
// skid-buffer state encoding and the buffered entry payload.
package alu_result_stage_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CCR_W  = 32;

    localparam logic [DATA_W-1:0] OP_NOP = DATA_W'(0);
    localparam logic [DATA_W-1:0] OP_BEQ = DATA_W'(39);
    localparam logic [DATA_W-1:0] OP_BNE = DATA_W'(40);
    localparam logic [DATA_W-1:0] OP_BLT = DATA_W'(41);

    localparam int unsigned CCR_C   = 0;
    localparam int unsigned CCR_N   = 1;
    localparam int unsigned CCR_V   = 2;
    localparam int unsigned CCR_Z   = 3;
    localparam int unsigned CCR_INR = 4;
    localparam int unsigned CCR_NOP = 5;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] op;
        logic [DATA_W-1:0] rz;
        logic              br_taken;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/alu_result_stage_skid_buffer_2.sv
// Two-entry skid buffer: registered head plus one skid slot, strict FIFO order,
// in_ready and out_valid both registered from the next occupancy state.
module alu_result_stage_skid_buffer_2
    import alu_result_stage_pkg::*;
#(
    parameter int unsigned W = ENTRY_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_e  state;
    skid_state_e  state_nxt;
    logic [W-1:0] skid;
    logic         accept;
    logic         drain;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    // Occupancy transition; feeds the registered ready/valid flags.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (accept) state_nxt = ST_ONE;
            ST_ONE: begin
                if (accept && !drain)      state_nxt = ST_TWO;
                else if (drain && !accept) state_nxt = ST_EMPTY;
            end
            ST_TWO:   if (drain) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            skid      <= '0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt != ST_TWO);
            out_valid <= (state_nxt != ST_EMPTY);
            case (state)
                ST_EMPTY: if (accept) out_data <= in_data;
                ST_ONE: begin
                    if (accept && drain) out_data <= in_data;
                    else if (accept)     skid     <= in_data;
                end
                ST_TWO:   if (drain) out_data <= skid;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Stage after the ALU: owns the CCR, resolves branch-taken from the branch's own
// flags, and queues op/rz/taken to writeback through a 2-entry skid buffer.
module alu_result_stage
    import alu_result_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_op,
    input  logic [DATA_W-1:0] in_rz,
    input  logic              in_c,
    input  logic              in_v,
    input  logic              in_z,
    input  logic              in_n,
    input  logic              in_inr,
    input  logic              in_ccr_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op,
    output logic [DATA_W-1:0] out_rz,
    output logic              out_br_taken,
    output logic [CCR_W-1:0]  ccr_q,
    output logic              ccr_carry
);

    entry_t in_entry;
    entry_t head;
    logic   accept;
    logic   br_taken;

    assign accept = in_valid & in_ready;

    // Condition comes from the branch's own compare, not the architectural CCR.
    always_comb begin
        br_taken = 1'b0;
        if (in_op == OP_BEQ)      br_taken = in_z;
        else if (in_op == OP_BNE) br_taken = ~in_z;
        else if (in_op == OP_BLT) br_taken = in_n ^ in_v;
    end

    assign in_entry = '{op: in_op, rz: in_rz, br_taken: br_taken};

    alu_result_stage_skid_buffer_2 #(.W(ENTRY_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    assign out_op       = head.op;
    assign out_rz       = head.rz;
    assign out_br_taken = head.br_taken;

    // CCR follows program order at accept time, regardless of writeback stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            ccr_q <= '0;
        end else if (accept) begin
            if (in_op == OP_NOP) begin
                ccr_q[CCR_NOP] <= 1'b1;
            end else if (in_ccr_en) begin
                ccr_q          <= '0;
                ccr_q[CCR_C]   <= in_c;
                ccr_q[CCR_N]   <= in_n;
                ccr_q[CCR_V]   <= in_v;
                ccr_q[CCR_Z]   <= in_z;
                ccr_q[CCR_INR] <= in_inr;
            end
        end
    end

    assign ccr_carry = ccr_q[CCR_C];

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: queue/CCR reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_op;
    logic [31:0] in_rz;
    logic        in_c, in_v, in_z, in_n, in_inr, in_ccr_en;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_op;
    logic [31:0] out_rz;
    logic        out_br_taken;
    logic [31:0] ccr_q;
    logic        ccr_carry;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_result_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rz(in_rz),
        .in_c(in_c), .in_v(in_v), .in_z(in_z), .in_n(in_n), .in_inr(in_inr),
        .in_ccr_en(in_ccr_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_rz(out_rz), .out_br_taken(out_br_taken),
        .ccr_q(ccr_q), .ccr_carry(ccr_carry)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO of pending results, CCR value, and source-side ready.
    typedef struct {
        logic [31:0] op;
        logic [31:0] rz;
        logic        br;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_ccr = '0;
    logic        m_rdy = 1'b0;
    bit          m_live = 1'b0;

    function automatic logic branch_rule(input logic [31:0] op, input logic z, n, v);
        case (op)
            32'd39:  return z;
            32'd40:  return !z;
            32'd41:  return n ^ v;
            default: return 1'b0;
        endcase
    endfunction

    // Inputs are stable between negedge and the next posedge, so the model steps here.
    always @(negedge clk) begin
        exp_t e;
        bit   acc, drn;
        if (m_live) begin
            check("out_valid", 32'(out_valid), 32'(q.size() > 0));
            check("in_ready", 32'(in_ready), 32'(m_rdy));
            check("ccr_q", ccr_q, m_ccr);
            check("ccr_carry", 32'(ccr_carry), 32'(m_ccr[0]));
            if (q.size() > 0) begin
                check("head_op", out_op, q[0].op);
                check("head_rz", out_rz, q[0].rz);
                check("head_br", 32'(out_br_taken), 32'(q[0].br));
            end
        end
        if (rst) begin
            m_live = 1'b1;
            q.delete();
            m_ccr = '0;
            m_rdy = 1'b0;
        end else if (m_live) begin
            acc = in_valid && m_rdy;
            drn = (q.size() > 0) && out_ready;
            if (drn) void'(q.pop_front());
            if (acc) begin
                e.op = in_op;
                e.rz = in_rz;
                e.br = branch_rule(in_op, in_z, in_n, in_v);
                q.push_back(e);
                if (in_op == 32'd0)
                    m_ccr = m_ccr | 32'h20;
                else if (in_ccr_en)
                    m_ccr = {27'd0, in_inr, in_z, in_v, in_n, in_c};
            end
            m_rdy = (q.size() < 2);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one result and hold it until the stage takes it.
    task automatic send(input logic [31:0] op, input logic [31:0] rz,
                        input logic c, v, z, n, inr, en);
        bit acc;
        in_op = op; in_rz = rz;
        in_c = c; in_v = v; in_z = z; in_n = n; in_inr = inr; in_ccr_en = en;
        in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: op %0d not accepted within 40 cycles", op);
        end
    endtask

    initial begin
        logic [31:0] ops [6];
        ops[0] = 32'd0; ops[1] = 32'd1; ops[2] = 32'd9;
        ops[3] = 32'd39; ops[4] = 32'd40; ops[5] = 32'd41;

        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_rz = '0;
        in_c = 0; in_v = 0; in_z = 0; in_n = 0; in_inr = 0; in_ccr_en = 0;
        out_ready = 1'b1;
        repeat (2) step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_op", out_op, 32'd0);
        check("rst_ccr", ccr_q, 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // ADD: visible the cycle after accept, flags all zero.
        send(32'd1, 32'd5, 0, 0, 0, 0, 0, 1);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_rz", out_rz, 32'd5);
        check("t1_ccr", ccr_q, 32'd0);

        // Branch resolution from the branch's own flags.
        send(32'd2, 32'd0, 0, 0, 1, 0, 0, 1);
        send(32'd39, 32'd0, 0, 0, 1, 0, 0, 1);
        check("t2_beq", 32'(out_br_taken), 32'd1);
        send(32'd40, 32'd0, 0, 0, 1, 0, 0, 1);
        check("t2_bne", 32'(out_br_taken), 32'd0);
        send(32'd41, 32'd0, 0, 0, 0, 1, 0, 1);
        check("t2_blt", 32'(out_br_taken), 32'd1);
        step();

        // Stall writeback with three back-to-back results.
        out_ready = 1'b0;
        send(32'd3, 32'd100, 0, 0, 0, 0, 0, 0);
        send(32'd3, 32'd101, 0, 0, 0, 0, 0, 0);
        check("t3_full_ready", 32'(in_ready), 32'd0);
        check("t3_head_held", out_rz, 32'd100);
        fork
            send(32'd3, 32'd102, 0, 0, 0, 0, 0, 0);
            begin
                repeat (3) step();
                check("t3_head_still", out_rz, 32'd100);
                out_ready = 1'b1;
            end
        join
        repeat (4) step();

        // CCR updates at accept even while writeback is stalled.
        out_ready = 1'b0;
        send(32'd9, 32'd7, 1, 0, 0, 0, 0, 1);
        check("t4_ccr", ccr_q, 32'h1);
        check("t4_carry", 32'(ccr_carry), 32'd1);
        out_ready = 1'b1;
        repeat (2) step();

        // NOP only sets the NOP bit.
        send(32'd0, 32'd0, 0, 0, 1, 0, 0, 1);
        check("t5_ccr", ccr_q, 32'h21);
        check("t5_op", out_op, 32'd0);
        check("t5_br", 32'(out_br_taken), 32'd0);
        repeat (2) step();

        // Reset with both entries occupied.
        out_ready = 1'b0;
        send(32'd1, 32'd11, 0, 0, 0, 0, 0, 1);
        send(32'd1, 32'd12, 1, 0, 0, 0, 0, 1);
        check("t6_full", 32'(in_ready), 32'd0);
        rst = 1'b1;
        step();
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_ccr", ccr_q, 32'd0);
        check("t6_ready_in_rst", 32'(in_ready), 32'd0);
        check("t6_rz", out_rz, 32'd0);
        rst = 1'b0;
        step();
        check("t6_ready_after", 32'(in_ready), 32'd1);
        check("t6_valid_after", 32'(out_valid), 32'd0);

        // Mixed traffic with random backpressure, checked by the model.
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_op     = ops[$urandom_range(0, 5)];
            in_rz     = $urandom;
            in_c      = 1'($urandom_range(0, 1));
            in_v      = 1'($urandom_range(0, 1));
            in_z      = 1'($urandom_range(0, 1));
            in_n      = 1'($urandom_range(0, 1));
            in_inr    = 1'($urandom_range(0, 1));
            in_ccr_en = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
